fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch front end. Produces the 32-bit `Instr` word that the instruction decoder consumes, and consumes the decoder's `PCSrc` redirect and branch/jump target.
- Owns the PC register and speaks a valid/ready request/response protocol to instruction memory.
- Holds a fetched instruction until decode accepts it.
- Supports one outstanding memory request, drops stale responses after a redirect, and flags misaligned targets.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, value driven on `Instr` when no valid instruction is held (addi x0,x0,0).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_req_addr  output  32  word-aligned fetch address (= pc).
- imem_resp_valid  input  1  response data valid; in order, at least 1 cycle after acceptance.
- imem_resp_data  input  32  fetched instruction word.
- redirect_valid  input  1  PCSrc from control: take redirect this cycle.
- redirect_target  input  32  jump/branch target computed by the ALU.
- instr_valid  output  1  Instr holds a valid instruction.
- instr_ready  input  1  decode consumes Instr this cycle.
- Instr  output  32  instruction to the decoder.
- instr_pc  output  32  address of Instr.
- instr_pc_plus4  output  32  instr_pc+4, modulo 2^32; feeds the jal/jalr link value.
- instr_misaligned  output  1  Instr was fetched as the first instruction after a redirect whose target[1:0]!=0.

Behaviour:
- Reset (async, while rst=1), all held immediately:
  - state=REQ, pc=RESET_PC
  - instr_valid=0, Instr=NOP_INSTR, instr_pc=RESET_PC, instr_pc_plus4=RESET_PC+4
  - instr_misaligned=0, imem_req_valid=0
  - pending-misalign flag=0
- First request: imem_req_valid rises on the first clock edge after rst deasserts.
- imem_req_valid=1 only in REQ. imem_req_addr=pc always. instr_valid=1 only in HOLD.
- State REQ:
  - Handshake (imem_req_valid & imem_req_ready) -> WAIT.
  - redirect_valid without handshake -> pc<=target, stay REQ.
  - redirect_valid with handshake -> pc<=target, go to DROP; the in-flight response belongs to the old pc.
  - Any imem_resp_valid seen in REQ is ignored.
- State WAIT:
  - imem_resp_valid -> Instr<=resp_data, instr_pc<=pc, pc<=pc+4, HOLD.
  - redirect_valid without response -> pc<=target, DROP.
  - redirect_valid and response in the same cycle -> response discarded, pc<=target, REQ.
- State DROP:
  - imem_resp_valid -> discard, REQ.
  - redirect_valid -> pc<=target, stay DROP.
  - Redirect and response in the same cycle -> pc<=target, REQ.
- State HOLD:
  - Instr, instr_pc, instr_pc_plus4 and instr_misaligned are stable.
  - instr_ready -> REQ.
  - redirect_valid (with or without instr_ready) -> held instruction squashed (instr_valid=0 next cycle), pc<=target, REQ.
- Redirect priority: redirect always wins over sequential increment.
- Misaligned targets:
  - pc<=target with bits [1:0] forced to 00.
  - A pending-misalign flag is set when target[1:0]!=0 and cleared when any redirect with target[1:0]==00 arrives.
  - The flag transfers to instr_misaligned on the next captured response, then clears.
- Arithmetic:
  - pc+4 and instr_pc_plus4 wrap modulo 2^32; 0xFFFF_FFFC+4 = 0x0000_0000.
- Throughput: 1 instruction per 3 cycles minimum (REQ, WAIT, HOLD) with zero-wait memory.
- Outside HOLD, Instr keeps its last captured value; decode must qualify it with instr_valid.
- Reset mid-operation: instruction memory shares rst, so no response survives reset; a stray response arriving in REQ is ignored.

Decomposition:
- Shared package `fetch_pkg`: enum fetch_state_t {REQ, WAIT, HOLD, DROP}, NOP_INSTR constant, default RESET_PC.
- No sub-module: PC register and FSM are one always_ff plus one always_comb.

Test Plan:
- Reset and first fetch:
  - Stimulus: rst=1 for 2 cycles; req_ready=1; memory returns 0x0050_0093 one cycle after acceptance.
  - Response: req addr 0x0; then instr_valid=1, Instr=0x0050_0093, instr_pc=0x0, instr_pc_plus4=0x4; next req addr 0x4.
- Decode stall:
  - Stimulus: instr_ready=0 for 5 cycles while in HOLD.
  - Response: Instr and instr_pc stable, imem_req_valid=0 throughout; on instr_ready=1, next request at 0x8.
- Redirect while waiting:
  - Stimulus: redirect to 0x100 in WAIT; stale response 0xDEAD_BEEF arrives 2 cycles later.
  - Response: instr_valid stays 0; next req addr 0x100.
- Redirect and response in the same cycle:
  - Stimulus: redirect to 0x200 in the same cycle as imem_resp_valid.
  - Response: data discarded; REQ with addr 0x200 on the next cycle.
- Misaligned redirect:
  - Stimulus: target 0x0000_0102.
  - Response: req addr 0x100; delivered Instr has instr_misaligned=1; the following instruction (pc 0x104) has instr_misaligned=0.
- Wrap and reset mid-operation:
  - Stimulus: redirect to 0xFFFF_FFFC.
  - Response: instr_pc_plus4=0x0, next req addr 0x0.
  - Stimulus: assert rst while in WAIT.
  - Response: instr_valid=0 and imem_req_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

  // REQ: issue a fetch; WAIT: fetch in flight; HOLD: instruction waiting for
  // decode; DROP: a fetch is in flight but its pc was redirected away.
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Clear the two low bits so every fetch address is word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the pc, issues one imem request at a time, holds the result for decode.
// Latency: request -> instruction valid is 1 cycle plus memory latency; at best 1 instruction per 3 cycles.
// Backpressure: instr_ready low keeps the instruction held and no new request is issued.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = fetch_pkg::DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] Instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4,
  output logic        instr_misaligned
);
  import fetch_pkg::*;

  fetch_state_t state;
  fetch_state_t state_nxt;
  logic [31:0]  pc;
  logic [31:0]  pc_nxt;
  logic [31:0]  instr_q;
  logic [31:0]  instr_pc_q;
  logic         started;
  logic         misalign_pend;
  logic         misalign_q;
  logic         req_fire;
  logic         capture;

  // started keeps the request low during reset and until the first edge after it.
  assign imem_req_valid   = started && (state == REQ);
  assign imem_req_addr    = pc;
  assign instr_valid      = (state == HOLD);
  assign Instr            = instr_q;
  assign instr_pc         = instr_pc_q;
  assign instr_pc_plus4   = instr_pc_q + 32'd4;
  assign instr_misaligned = misalign_q;

  // Next state and next pc; a redirect always overrides the sequential pc.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    capture   = 1'b0;
    req_fire  = imem_req_valid && imem_req_ready;
    case (state)
      REQ: begin
        // A redirect in the same cycle as acceptance leaves a stale fetch in flight.
        if (req_fire) state_nxt = redirect_valid ? DROP : WAIT;
      end
      WAIT: begin
        if (imem_resp_valid) begin
          if (redirect_valid) begin
            state_nxt = REQ;
          end else begin
            capture   = 1'b1;
            pc_nxt    = pc + 32'd4;
            state_nxt = HOLD;
          end
        end else if (redirect_valid) begin
          state_nxt = DROP;
        end
      end
      HOLD: begin
        if (redirect_valid || instr_ready) state_nxt = REQ;
      end
      DROP: begin
        if (imem_resp_valid) state_nxt = REQ;
      end
      default: state_nxt = REQ;
    endcase
    if (redirect_valid) pc_nxt = align_word(redirect_target);
  end

  // State, pc, captured instruction and misalign tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= REQ;
      pc            <= RESET_PC;
      started       <= 1'b0;
      instr_q       <= NOP_INSTR;
      instr_pc_q    <= RESET_PC;
      misalign_pend <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      started <= 1'b1;
      state   <= state_nxt;
      pc      <= pc_nxt;
      if (capture) begin
        instr_q    <= imem_resp_data;
        instr_pc_q <= pc;
        misalign_q <= misalign_pend;
      end
      // Capture and redirect never coincide, so the two updates are exclusive.
      if (redirect_valid) misalign_pend <= |redirect_target[1:0];
      else if (capture)   misalign_pend <= 1'b0;
    end
  end

endmodule
